// File: rtl/mdu_sequencer_if.sv
// Decoder-to-MDU handshake bundle: launch/op fields and operands in,
// busy flag, HI/LO read-back and architectural registers out.
interface mdu_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
);
  logic             Start;
  logic [3:0]       MDUOP;
  logic [CNT_W-1:0] Time;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       ReadHILO;
  logic             Busy;
  logic [WIDTH-1:0] RData;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, MDUOP, Time, A, B, ReadHILO,
    input  Busy, RData, HI, LO
  );

  modport slave (
    input  Start, MDUOP, Time, A, B, ReadHILO,
    output Busy, RData, HI, LO
  );
endinterface

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer: latches operands on launch, counts the
// op latency down and commits the result to HI/LO on the final edge.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  mdu_sequencer_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_BDS   = 4'b1000;

  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               w_launch;
  logic               w_commit;
  logic               w_move_ok;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic               w_res_we;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_sq_mag;
  logic [WIDTH-1:0]   w_sr_mag;
  logic [WIDTH-1:0]   w_sq;
  logic [WIDTH-1:0]   w_sr;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;

  function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] c;
    c = W_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{(WIDTH-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Sign-extended operands make the low 2*WIDTH bits of a plain product signed-correct
  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_u = {W_ZERO, r_a} * {W_ZERO, r_b};

  // Signed divide via magnitudes: truncation toward zero, and MIN / -1 yields MIN, rem 0
  assign w_a_neg  = r_a[WIDTH-1];
  assign w_b_neg  = r_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~r_a + W_ONE) : r_a;
  assign w_b_mag  = w_b_neg ? (~r_b + W_ONE) : r_b;
  assign w_sq_mag = w_a_mag / w_b_mag;
  assign w_sr_mag = w_a_mag % w_b_mag;
  assign w_sq     = (w_a_neg ^ w_b_neg) ? (~w_sq_mag + W_ONE) : w_sq_mag;
  assign w_sr     = w_a_neg ? (~w_sr_mag + W_ONE) : w_sr_mag;
  assign w_uq     = r_a / r_b;
  assign w_ur     = r_a % r_b;

  assign w_launch  = (r_state == ST_IDLE) && bus.Start;
  assign w_move_ok = (r_state == ST_IDLE) && !bus.Start;

  // Result selection from latched operands; divide by zero leaves HI/LO alone
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_res_we = 1'b0;
    case (r_op)
      OP_MULT: begin
        w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_s[WIDTH-1:0];
        w_res_we = 1'b1;
      end
      OP_MULTU: begin
        w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_u[WIDTH-1:0];
        w_res_we = 1'b1;
      end
      OP_DIV: begin
        if (r_b != W_ZERO) begin
          w_res_hi = w_sr;
          w_res_lo = w_sq;
          w_res_we = 1'b1;
        end else begin
          w_res_we = 1'b0;
        end
      end
      OP_DIVU: begin
        if (r_b != W_ZERO) begin
          w_res_hi = w_ur;
          w_res_lo = w_uq;
          w_res_we = 1'b1;
        end else begin
          w_res_we = 1'b0;
        end
      end
      OP_BDS: begin
        w_res_hi = W_ZERO;
        w_res_lo = popcount(r_a ^ r_b);
        w_res_we = 1'b1;
      end
      default: begin
        w_res_we = 1'b0;
      end
    endcase
  end

  // Next state and latency counter; commit fires on the edge leaving cnt==1
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Start) begin
          w_state_next = ST_RUN;
          w_cnt_next   = (bus.Time == C_ZERO) ? C_ONE : bus.Time;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == C_ONE) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = C_ZERO;
          w_commit     = 1'b1;
        end else begin
          w_cnt_next   = r_cnt - C_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = C_ZERO;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= C_ZERO;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Operand latch on launch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= 4'b0000;
      r_a  <= W_ZERO;
      r_b  <= W_ZERO;
    end else if (w_launch) begin
      r_op <= bus.MDUOP;
      r_a  <= bus.A;
      r_b  <= bus.B;
    end
  end

  // Architectural HI/LO: commits and moves never coincide (RUN vs IDLE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= W_ZERO;
      r_lo <= W_ZERO;
    end else if (w_commit && w_res_we) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (w_move_ok && (bus.MDUOP == OP_MTHI)) begin
      r_hi <= bus.A;
    end else if (w_move_ok && (bus.MDUOP == OP_MTLO)) begin
      r_lo <= bus.A;
    end
  end

  // Read-back mux feeding the E-stage result
  always_comb begin
    bus.RData = W_ZERO;
    case (bus.ReadHILO)
      2'b10:   bus.RData = r_hi;
      2'b01:   bus.RData = r_lo;
      default: bus.RData = W_ZERO;
    endcase
  end

  assign bus.Busy = bus.Start | (r_cnt != C_ZERO);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule
